adc_ok_reader: RTL

ADC_OK_READER -- requirements
Module: adc_ok_reader

---
 rtl/adc_ok_reader_pkg.sv | 21 ++
 rtl/adc_ok_reader_if.sv | 20 ++
 rtl/byte_fifo_fwft.sv | 56 +++++
 rtl/adc_ok_reader.sv | 121 ++++++++++++
 4 files changed

// File: rtl/adc_ok_reader_pkg.sv
// rtl/adc_ok_reader_pkg.sv - shared types and constants for the ADC reader
package adc_ok_reader_pkg;

  localparam int SAMPLE_BITS    = 16;
  localparam int DEF_SCLK_DIV   = 2;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_PUSH_HI  = 3'd4,
    ST_PUSH_LO  = 3'd5
  } reader_state_e;

  function automatic logic [7:0] sample_byte(input logic [15:0] s, input logic hi);
    return hi ? s[15:8] : s[7:0];
  endfunction

endpackage

// File: rtl/adc_ok_reader_if.sv
// rtl/adc_ok_reader_if.sv - host pipe-out byte interface
interface adc_ok_reader_if;

  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_rd;

  modport master (
    output dout,
    output dout_valid,
    input  dout_rd
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_rd
  );

endinterface

// File: rtl/byte_fifo_fwft.sv
// rtl/byte_fifo_fwft.sv - first-word-fall-through byte FIFO, power-of-two depth
module byte_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle
  assign do_wr   = wr_en && ((count != FULL) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_ok_reader.sv
// rtl/adc_ok_reader.sv - serial ADC conversion reader feeding a byte FIFO
module adc_ok_reader #(
  parameter int SCLK_DIV    = adc_ok_reader_pkg::DEF_SCLK_DIV,
  parameter int SAMPLE_BITS = adc_ok_reader_pkg::SAMPLE_BITS,
  parameter int FIFO_DEPTH  = adc_ok_reader_pkg::DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            read_trig,
  input  logic            adc_dout,
  output logic            adc_cs,
  output logic            adc_sclk,
  adc_ok_reader_if.master pipe,
  output logic            busy,
  output logic            ack_data,
  output logic            overflow
);

  import adc_ok_reader_pkg::*;

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF_W = $clog2(2 * SAMPLE_BITS);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] CS_SETUP = ST_CS_SETUP;
  localparam logic [2:0] SHIFT    = ST_SHIFT;
  localparam logic [2:0] CS_HOLD  = ST_CS_HOLD;
  localparam logic [2:0] PUSH_HI  = ST_PUSH_HI;
  localparam logic [2:0] PUSH_LO  = ST_PUSH_LO;

  localparam logic [7:0]        DIV_LAST  = 8'(SCLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * SAMPLE_BITS - 1);
  // Highest occupancy that still leaves room for both bytes of a sample
  localparam logic [CNT_W-1:0]  PAIR_FIT  = CNT_W'(FIFO_DEPTH - 2);

  logic [2:0]             state;
  logic [7:0]             div_cnt;
  logic [HALF_W-1:0]      half_cnt;
  logic [SAMPLE_BITS-1:0] sample;

  logic                   fifo_wr;
  logic [7:0]             fifo_wdata;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  assign busy       = (state != IDLE);
  assign ack_data   = (state == PUSH_LO);
  assign fifo_wr    = (state == PUSH_HI) || (state == PUSH_LO);
  assign fifo_wdata = sample_byte(16'(sample), state == PUSH_HI);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      adc_cs   <= 1'b1;
      adc_sclk <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sample   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_trig) begin
            state  <= CS_SETUP;
            adc_cs <= 1'b0;
          end
        end
        CS_SETUP: begin
          state    <= SHIFT;
          adc_sclk <= 1'b0;
          div_cnt  <= '0;
          half_cnt <= '0;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            adc_sclk <= ~adc_sclk;
            half_cnt <= half_cnt + 1'b1;
            // Capture on the edge where sclk rises; the ADC changes data on the falling edge
            if (!adc_sclk) begin
              sample <= {sample[SAMPLE_BITS-2:0], adc_dout};
            end
            if (half_cnt == HALF_LAST) begin
              state  <= CS_HOLD;
              adc_cs <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        CS_HOLD: begin
          if (fifo_count <= PAIR_FIT) begin
            state <= PUSH_HI;
          end else begin
            overflow <= 1'b1;
            state    <= IDLE;
          end
        end
        PUSH_HI: state <= PUSH_LO;
        PUSH_LO: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  byte_fifo_fwft #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (pipe.dout_rd),
    .rd_data (pipe.dout),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pipe.dout_valid = !fifo_empty;

endmodule
